sad_accumulate_ci: RTL and testbench
====================================

// Module: sad_accumulate_ci
// PURPOSE
//  Multi-cycle custom instruction for the optic-flow pipeline. Accumulates a running sum of
//  absolute differences (SAD) between packed pixel lanes of valueA and valueB. Also counts
//  lanes whose difference exceeds a motion threshold. Sits on the CPU custom-instruction bus
//  beside the combinational abs-diff instruction and replaces software SAD loops.
// PARAMETERS
//  customInstructionId  8'd30  ciN of ACCUM op; ciN == customInstructionId+1 selects READ op
//  NR_OF_LANES          4      pixel lanes per operand word
//  PIXEL_WIDTH          8      bits per lane; NR_OF_LANES*PIXEL_WIDTH <= 32
//  THRESHOLD            20     lane counts as motion when |A-B| > THRESHOLD (strict)
//  ACC_WIDTH            32     SAD and motion-count register width, <= 32
// PORTS
//  clock   in   1   single clock, rising edge
//  reset   in   1   asynchronous, active-low reset
//  start   in   1   one-cycle request strobe
//  ciN     in   8   instruction id
//  valueA  in   32  ACCUM: lane i = valueA[i*PIXEL_WIDTH +: PIXEL_WIDTH]; READ: bit0 selects register
//  valueB  in   32  ACCUM: lane i as valueA; READ: bit0=1 clears both registers after read
//  done    out  1   one-cycle completion pulse
//  result  out  32  valid only while done=1, else 32'd0
// BEHAVIOUR
//  - Reset (reset=0, async): done=0, result=0, sadAcc=0, motionCnt=0, state IDLE, pipeline flushed.
//  - States: IDLE, ACC1, ACC2, READ. Request accepted only in IDLE when start=1 and ciN matches.
//  - start with non-matching ciN: ignored, no done, no state change.
//  - start in any non-IDLE state: ignored; not queued.
//  - ACCUM (ciN==id), latency 2:
//      cycle 0: start seen; per-lane |A-B| (unsigned, PIXEL_WIDTH bits) and lane>THRESHOLD flags registered -> ACC1.
//      cycle 1: lane sum (PIXEL_WIDTH+clog2(NR_OF_LANES) bits) and flag popcount added to sadAcc/motionCnt -> ACC2.
//      cycle 2: done=1, result=updated sadAcc zero-extended to 32 -> IDLE.
//  - sadAcc and motionCnt saturate at 2^ACC_WIDTH-1 independently; no wrap-around.
//  - READ (ciN==id+1), latency 1:
//      cycle 1: done=1, result = valueA[0] ? motionCnt : sadAcc (operands captured at start) -> IDLE.
//      If valueB[0]=1, both registers cleared in the done cycle; the returned value is the pre-clear value.
//  - done never high two consecutive cycles. New start accepted in the cycle after done (IDLE again).
//  - Reset mid-operation: in-flight op aborted; no done; registers zero.
// TESTING
//  - Reset, ACCUM A={40,17,17,19}, B=0 -> done exactly 2 cycles after start, result=93; motionCnt=1.
//  - Next ACCUM A=0, B={255,255,255,255} -> result=1113; READ valueA=1,valueB=0 -> done after 1 cycle, result=5.
//  - READ valueA=0,valueB=1 -> result=1113; following READ valueA=0 -> result=0; READ valueA=1 -> 0.
//  - start=1, ciN=47 held 4 cycles -> done stays 0, result stays 0; later READ shows state unchanged.
//  - start=1 during ACC1 with READ ciN -> ignored; only one done pulse (ACCUM result).
//  - ACC_WIDTH=10: two ACCUMs of A=0,B=all 255 -> results 1020 then 1023 (saturated).
//  - reset pulsed low during ACC1 -> no done; subsequent READ of SAD -> result=0.

Source files
------------

// File: rtl/sad_accumulate_ci.sv
// Multi-cycle custom instruction: accumulates a saturating sum of absolute lane differences
// and a count of lanes whose difference exceeds a motion threshold; READ returns either register.
module sad_accumulate_ci #(
  parameter logic [7:0] customInstructionId = 8'd30,
  parameter int         NR_OF_LANES         = 4,
  parameter int         PIXEL_WIDTH         = 8,
  parameter int         THRESHOLD           = 20,
  parameter int         ACC_WIDTH           = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  state_dbg
);

  localparam int SUM_W = PIXEL_WIDTH + $clog2(NR_OF_LANES);
  localparam int CNT_W = $clog2(NR_OF_LANES + 1);
  localparam logic [7:0] READ_ID = customInstructionId + 8'd1;
  localparam logic [PIXEL_WIDTH-1:0] THR = PIXEL_WIDTH'(THRESHOLD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC1 = 2'd1;
  localparam logic [1:0] ACC2 = 2'd2;
  localparam logic [1:0] READ = 2'd3;

  // Handshake: start is a one-cycle strobe that is only looked at in IDLE (never queued);
  // done is a one-cycle pulse carrying result, with no backpressure from the requester.
  logic [1:0]             state;
  logic [PIXEL_WIDTH-1:0] diff_d [NR_OF_LANES];
  logic [PIXEL_WIDTH-1:0] diff_q [NR_OF_LANES];
  logic [NR_OF_LANES-1:0] flag_d, flag_q;
  logic [ACC_WIDTH-1:0]   sad_acc, motion_cnt;
  logic [ACC_WIDTH-1:0]   sad_sat, motion_sat;
  logic [ACC_WIDTH:0]     sad_sum, motion_sum;
  logic [SUM_W-1:0]       lane_sum;
  logic [CNT_W-1:0]       lane_pop;
  logic                   rd_sel, rd_clr;

  always_comb begin
    flag_d = '0;
    for (int i = 0; i < NR_OF_LANES; i++) begin
      if (valueA[i*PIXEL_WIDTH +: PIXEL_WIDTH] > valueB[i*PIXEL_WIDTH +: PIXEL_WIDTH])
        diff_d[i] = valueA[i*PIXEL_WIDTH +: PIXEL_WIDTH] - valueB[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      else
        diff_d[i] = valueB[i*PIXEL_WIDTH +: PIXEL_WIDTH] - valueA[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      flag_d[i] = diff_d[i] > THR;
    end
  end

  always_comb begin
    lane_sum = '0;
    lane_pop = '0;
    for (int i = 0; i < NR_OF_LANES; i++) begin
      lane_sum = lane_sum + SUM_W'(diff_q[i]);
      lane_pop = lane_pop + CNT_W'(flag_q[i]);
    end
  end

  // One extra carry bit detects overflow; on overflow the register pins at all-ones.
  always_comb begin
    sad_sum    = {1'b0, sad_acc} + (ACC_WIDTH+1)'(lane_sum);
    motion_sum = {1'b0, motion_cnt} + (ACC_WIDTH+1)'(lane_pop);
    sad_sat    = sad_sum[ACC_WIDTH] ? '1 : sad_sum[ACC_WIDTH-1:0];
    motion_sat = motion_sum[ACC_WIDTH] ? '1 : motion_sum[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flag_q     <= '0;
      sad_acc    <= '0;
      motion_cnt <= '0;
      rd_sel     <= 1'b0;
      rd_clr     <= 1'b0;
      for (int i = 0; i < NR_OF_LANES; i++) diff_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && ciN == customInstructionId) begin
            diff_q <= diff_d;
            flag_q <= flag_d;
            state  <= ACC1;
          end else if (start && ciN == READ_ID) begin
            rd_sel <= valueA[0];
            rd_clr <= valueB[0];
            state  <= READ;
          end
        end
        ACC1: begin
          sad_acc    <= sad_sat;
          motion_cnt <= motion_sat;
          state      <= ACC2;
        end
        ACC2: state <= IDLE;
        READ: begin
          // Result is driven from the pre-clear value during this cycle.
          if (rd_clr) begin
            sad_acc    <= '0;
            motion_cnt <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    done   = (state == ACC2) || (state == READ);
    result = '0;
    if (state == ACC2)
      result[ACC_WIDTH-1:0] = sad_acc;
    else if (state == READ)
      result[ACC_WIDTH-1:0] = rd_sel ? motion_cnt : sad_acc;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sad_accumulate_ci.sv
// Bench for sad_accumulate_ci: a 32-bit and a 10-bit accumulator instance share stimulus and
// are checked every cycle against a transaction-level model plus literal expectations.
module tb_sad_accumulate_ci;

  localparam logic [7:0] ID = 8'd30;
  localparam logic [7:0] RD = 8'd31;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done, done_s;
  logic [31:0] result, result_s;
  logic [1:0]  st, st_s;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sad_accumulate_ci dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
    .done(done), .result(result), .state_dbg(st)
  );

  sad_accumulate_ci #(.ACC_WIDTH(10)) dut_s (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
    .done(done_s), .result(result_s), .state_dbg(st_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] m_sad, m_mot, m_sad_s, m_mot_s;
  logic [31:0] pend_res, pend_res_s;
  bit          exp_done = 1'b0;
  bit          prev_done;
  int          pend = 0;

  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc,
                                          input logic [32:0] maxv);
    logic [32:0] t;
    t = {1'b0, acc} + {1'b0, inc};
    return (t > maxv) ? maxv[31:0] : t[31:0];
  endfunction

  task automatic lane_stats(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] sum, output logic [31:0] mot);
    logic [7:0] x, y, d;
    sum = 0;
    mot = 0;
    for (int i = 0; i < 4; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      d = (x > y) ? x - y : y - x;
      sum = sum + {24'd0, d};
      if (d > 8'd20) mot = mot + 1;
    end
  endtask

  always @(posedge clock) begin
    logic [31:0] s, m;
    if (!reset) begin
      m_sad = 0; m_mot = 0; m_sad_s = 0; m_mot_s = 0;
      pend = 0; exp_done = 1'b0;
    end else begin
      prev_done = exp_done;
      exp_done  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) exp_done = 1'b1;
      end else if (!prev_done && start) begin
        if (ciN == ID) begin
          lane_stats(valueA, valueB, s, m);
          m_sad   = sat_add(m_sad,   s, 33'h0_FFFF_FFFF);
          m_mot   = sat_add(m_mot,   m, 33'h0_FFFF_FFFF);
          m_sad_s = sat_add(m_sad_s, s, 33'd1023);
          m_mot_s = sat_add(m_mot_s, m, 33'd1023);
          pend_res   = m_sad;
          pend_res_s = m_sad_s;
          pend = 1;
        end else if (ciN == RD) begin
          pend_res   = valueA[0] ? m_mot   : m_sad;
          pend_res_s = valueA[0] ? m_mot_s : m_sad_s;
          if (valueB[0]) begin
            m_sad = 0; m_mot = 0; m_sad_s = 0; m_mot_s = 0;
          end
          exp_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    check("cyc_done",     {31'd0, done},   {31'd0, exp_done});
    check("cyc_result",   result,          exp_done ? pend_res : 32'd0);
    check("cyc_done_s",   {31'd0, done_s}, {31'd0, exp_done});
    check("cyc_result_s", result_s,        exp_done ? pend_res_s : 32'd0);
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] r_s, output int lat);
    @(posedge clock); #1;
    start = 1'b1; ciN = c; valueA = a; valueB = b;
    @(posedge clock); #1;
    start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    lat = 0; r = 32'd0; r_s = 32'd0;
    for (int n = 1; n <= 8; n++) begin
      if (done) begin
        lat = n; r = result; r_s = result_s;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [31:0] r, rs;
    int lat;
    reset = 1'b0; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b1;

    do_op(ID, {8'd19, 8'd17, 8'd17, 8'd40}, 32'd0, r, rs, lat);
    check("acc1_lat", lat, 2); check("acc1", r, 93); check("acc1_s", rs, 93);
    do_op(ID, 32'd0, 32'hFFFF_FFFF, r, rs, lat);
    check("acc2", r, 1113); check("acc2_s", rs, 1023);
    do_op(RD, 32'd1, 32'd0, r, rs, lat);
    check("rd_mot_lat", lat, 1); check("rd_mot", r, 5); check("rd_mot_s", rs, 5);
    do_op(RD, 32'd0, 32'd1, r, rs, lat);
    check("rd_clr", r, 1113); check("rd_clr_s", rs, 1023);
    do_op(RD, 32'd0, 32'd0, r, rs, lat);
    check("rd_after_clr_sad", r, 0);
    do_op(RD, 32'd1, 32'd0, r, rs, lat);
    check("rd_after_clr_mot", r, 0);

    // lane diffs 20,0,21,21: 20 is not motion, 21 is
    do_op(ID, {8'd30, 8'd10, 8'd0, 8'd0}, {8'd9, 8'd31, 8'd0, 8'd20}, r, rs, lat);
    check("thr_sad", r, 62);
    do_op(RD, 32'd1, 32'd1, r, rs, lat);
    check("thr_mot", r, 2); check("thr_mot_s", rs, 2);
    do_op(RD, 32'd0, 32'd0, r, rs, lat);
    check("thr_clr", r, 0);

    do_op(ID, 32'd0, 32'hFFFF_FFFF, r, rs, lat);
    check("sat1", r, 1020); check("sat1_s", rs, 1020);
    do_op(ID, 32'd0, 32'hFFFF_FFFF, r, rs, lat);
    check("sat2", r, 2040); check("sat2_s", rs, 1023);

    @(posedge clock); #1;
    start = 1'b1; ciN = 8'd47; valueA = 32'd1; valueB = 32'd1;
    repeat (4) begin
      @(posedge clock); #1;
      check("bad_id_done", {31'd0, done}, 32'd0);
      check("bad_id_result", result, 32'd0);
    end
    start = 1'b0; ciN = 8'd0;
    do_op(RD, 32'd0, 32'd0, r, rs, lat);
    check("bad_id_state", r, 2040); check("bad_id_state_s", rs, 1023);

    @(posedge clock); #1;
    start = 1'b1; ciN = ID; valueA = 32'd5; valueB = 32'd0;
    @(posedge clock); #1;
    ciN = RD; valueA = 32'd1; valueB = 32'd1;
    @(posedge clock); #1;
    start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    check("busy_done", {31'd0, done}, 32'd1);
    check("busy_result", result, 2045); check("busy_result_s", result_s, 1023);
    repeat (4) begin
      @(posedge clock); #1;
      check("busy_no_extra", {31'd0, done}, 32'd0);
    end
    do_op(RD, 32'd1, 32'd0, r, rs, lat);
    check("busy_mot", r, 8); check("busy_mot_s", rs, 8);

    @(posedge clock); #1;
    start = 1'b1; ciN = ID; valueA = 32'd0; valueB = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    start = 1'b0; ciN = 8'd0; valueB = 32'd0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      @(posedge clock); #1;
    end
    do_op(RD, 32'd0, 32'd0, r, rs, lat);
    check("abort_sad", r, 0); check("abort_sad_s", rs, 0);
    do_op(RD, 32'd1, 32'd0, r, rs, lat);
    check("abort_mot", r, 0);

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
